// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: shares the single 64x64 RGB444 write port
// between two pixel requesters and sequences a full-screen clear sweep.
module fb_write_arbiter #(
    parameter logic [11:0] DEFAULT_CLEAR = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_start,
    input  logic [11:0] clear_color,
    output logic        clear_busy,
    input  logic        a_valid,
    input  logic [5:0]  a_x,
    input  logic [5:0]  a_y,
    input  logic [11:0] a_color,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [5:0]  b_x,
    input  logic [5:0]  b_y,
    input  logic [11:0] b_color,
    output logic        b_ready,
    output logic        write_en,
    output logic [5:0]  write_x,
    output logic [5:0]  write_y,
    output logic [11:0] pixel_color
);

    localparam int unsigned CNT_W = 12;
    localparam int unsigned XY_W  = 6;
    localparam int unsigned COL_W = 12;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last_b, last_b_nxt;
    logic [COL_W-1:0] clr_col, clr_col_nxt;
    logic             we_nxt;
    logic [XY_W-1:0]  x_nxt, y_nxt;
    logic [COL_W-1:0] col_nxt;
    logic             busy_nxt;
    logic             grant_a, grant_b;

    // Round-robin grant: the requester not served last wins a tie; a clear request blocks both
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == ST_ARB && !clear_start) begin
            grant_a = a_valid && (!b_valid || last_b);
            grant_b = b_valid && (!a_valid || !last_b);
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Next-state and next-output logic for arbitration and the clear sweep
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_b_nxt  = last_b;
        clr_col_nxt = clr_col;
        we_nxt      = 1'b0;
        x_nxt       = write_x;
        y_nxt       = write_y;
        col_nxt     = pixel_color;

        if (state == ST_CLEAR) begin
            we_nxt  = 1'b1;
            x_nxt   = cnt[XY_W-1:0];
            y_nxt   = cnt[CNT_W-1:XY_W];
            col_nxt = clr_col;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
                state_nxt = ST_ARB;
            end
        end else if (clear_start) begin
            state_nxt   = ST_CLEAR;
            cnt_nxt     = '0;
            clr_col_nxt = clear_color;
        end else if (grant_a) begin
            we_nxt     = 1'b1;
            x_nxt      = a_x;
            y_nxt      = a_y;
            col_nxt    = a_color;
            last_b_nxt = 1'b0;
        end else if (grant_b) begin
            we_nxt     = 1'b1;
            x_nxt      = b_x;
            y_nxt      = b_y;
            col_nxt    = b_color;
            last_b_nxt = 1'b1;
        end

        busy_nxt = (state_nxt == ST_CLEAR);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_ARB;
            cnt         <= '0;
            last_b      <= 1'b1;
            clr_col     <= DEFAULT_CLEAR;
            clear_busy  <= 1'b0;
            write_en    <= 1'b0;
            write_x     <= '0;
            write_y     <= '0;
            pixel_color <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last_b      <= last_b_nxt;
            clr_col     <= clr_col_nxt;
            clear_busy  <= busy_nxt;
            write_en    <= we_nxt;
            write_x     <= x_nxt;
            write_y     <= y_nxt;
            pixel_color <= col_nxt;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: cycle model plus pixel scoreboard.
module tb_fb_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_start;
    logic [11:0] clear_color;
    logic        clear_busy;
    logic        a_valid, b_valid;
    logic [5:0]  a_x, a_y, b_x, b_y;
    logic [11:0] a_color, b_color;
    logic        a_ready, b_ready;
    logic        write_en;
    logic [5:0]  write_x, write_y;
    logic [11:0] pixel_color;

    fb_write_arbiter #(.DEFAULT_CLEAR(12'h000)) dut (
        .clk(clk), .reset(reset),
        .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
        .a_valid(a_valid), .a_x(a_x), .a_y(a_y), .a_color(a_color), .a_ready(a_ready),
        .b_valid(b_valid), .b_x(b_x), .b_y(b_y), .b_color(b_color), .b_ready(b_ready),
        .write_en(write_en), .write_x(write_x), .write_y(write_y), .pixel_color(pixel_color)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard of expected writes: {x, y, color}
    logic [23:0] sb[$];

    // Reference model state
    logic        m_clear;
    logic [11:0] m_cnt;
    logic [11:0] m_ccol;
    logic        m_lastb;
    logic        m_we;
    logic [23:0] m_out;
    logic        a_acc, b_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clear = 1'b0;
        m_cnt   = '0;
        m_ccol  = 12'h000;
        m_lastb = 1'b1;
        m_we    = 1'b0;
        m_out   = '0;
        sb.delete();
    endtask

    // One clock cycle: check this cycle's outputs, then advance the model
    task automatic cycle();
        logic ga, gb;
        @(negedge clk);
        check("write_en", 32'(write_en), 32'(m_we));
        if (m_we && sb.size() > 0) m_out = sb.pop_front();
        check("write_x", 32'(write_x), 32'(m_out[23:18]));
        check("write_y", 32'(write_y), 32'(m_out[17:12]));
        check("pixel_color", 32'(pixel_color), 32'(m_out[11:0]));
        check("clear_busy", 32'(clear_busy), 32'(m_clear));
        ga = !m_clear && !clear_start && a_valid && (!b_valid || m_lastb);
        gb = !m_clear && !clear_start && b_valid && (!a_valid || !m_lastb);
        check("a_ready", 32'(a_ready), 32'(ga));
        check("b_ready", 32'(b_ready), 32'(gb));
        a_acc = ga;
        b_acc = gb;
        m_we  = 1'b0;
        if (m_clear) begin
            sb.push_back({m_cnt[5:0], m_cnt[11:6], m_ccol});
            m_we = 1'b1;
            if (m_cnt == 12'hFFF) m_clear = 1'b0;
            m_cnt = m_cnt + 12'd1;
        end else if (clear_start) begin
            m_clear = 1'b1;
            m_cnt   = '0;
            m_ccol  = clear_color;
        end else if (ga) begin
            sb.push_back({a_x, a_y, a_color});
            m_we = 1'b1;
            m_lastb = 1'b0;
        end else if (gb) begin
            sb.push_back({b_x, b_y, b_color});
            m_we = 1'b1;
            m_lastb = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    logic [23:0] pa[3];
    logic [23:0] pb[3];
    int ia, ib, waited, first_a;

    initial begin
        reset = 1'b1;
        clear_start = 1'b0; clear_color = '0;
        a_valid = 1'b0; a_x = '0; a_y = '0; a_color = '0;
        b_valid = 1'b0; b_x = '0; b_y = '0; b_color = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_clear_busy", 32'(clear_busy), 32'd0);
        check("rst_xy", 32'({write_x, write_y}), 32'd0);
        check("rst_color", 32'(pixel_color), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cycle();

        // Single A pixel
        a_valid = 1'b1; a_x = 6'd5; a_y = 6'd7; a_color = 12'hF00;
        cycle();
        check("single_a_acc", 32'(a_acc), 32'd1);
        a_valid = 1'b0;
        cycle();
        cycle();

        // One B pixel so A leads the alternation test
        b_valid = 1'b1; b_x = 6'd63; b_y = 6'd0; b_color = 12'h0AB;
        cycle();
        check("single_b_acc", 32'(b_acc), 32'd1);
        b_valid = 1'b0;
        cycle();

        // Both valid for 6 cycles: strict alternation
        pa[0] = {6'd1, 6'd2, 12'h111}; pa[1] = {6'd3, 6'd4, 12'h222}; pa[2] = {6'd0, 6'd63, 12'h333};
        pb[0] = {6'd9, 6'd8, 12'hAAA}; pb[1] = {6'd7, 6'd6, 12'hBBB}; pb[2] = {6'd63, 6'd63, 12'hCCC};
        ia = 0; ib = 0; first_a = -1;
        for (int k = 0; k < 6; k++) begin
            a_valid = 1'b1; {a_x, a_y, a_color} = pa[ia % 3];
            b_valid = 1'b1; {b_x, b_y, b_color} = pb[ib % 3];
            cycle();
            if (k == 0) first_a = int'(a_acc);
            if (a_acc) ia++;
            if (b_acc) ib++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("alt_first_a", 32'(first_a), 32'd1);
        check("alt_a_count", 32'(ia), 32'd3);
        check("alt_b_count", 32'(ib), 32'd3);
        cycle();
        cycle();

        // Clear sweep with A waiting and a re-pulsed clear_start mid-sweep
        clear_start = 1'b1; clear_color = 12'h00F;
        cycle();
        clear_start = 1'b0;
        a_valid = 1'b1; a_x = 6'd10; a_y = 6'd20; a_color = 12'h0F0;
        waited = 0;
        a_acc = 1'b0;
        while (!a_acc && waited < 5000) begin
            clear_start = (waited == 2001);
            clear_color = (waited == 2001) ? 12'hFFF : 12'h00F;
            cycle();
            waited++;
        end
        clear_start = 1'b0;
        a_valid = 1'b0;
        check("clear_a_wait", 32'(waited), 32'd4097);
        cycle();
        cycle();

        // Reset on the 1000th clear write
        clear_start = 1'b1; clear_color = 12'h0F0;
        cycle();
        clear_start = 1'b0;
        repeat (1000) cycle();
        check("pre_rst_write_en", 32'(write_en), 32'd1);
        check("pre_rst_x", 32'(write_x), 32'd39);
        reset = 1'b1;
        #1;
        check("async_write_en", 32'(write_en), 32'd0);
        check("async_clear_busy", 32'(clear_busy), 32'd0);
        check("async_xy", 32'({write_x, write_y}), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (5) cycle();

        // Tie after reset: A wins
        a_valid = 1'b1; a_x = 6'd33; a_y = 6'd44; a_color = 12'h5A5;
        b_valid = 1'b1; b_x = 6'd22; b_y = 6'd11; b_color = 12'hA5A;
        cycle();
        check("post_rst_tie_a", 32'(a_acc), 32'd1);
        a_valid = 1'b0;
        cycle();
        b_valid = 1'b0;
        cycle();
        cycle();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Owns the single write port of the 64x64, 12-bit RGB framebuffer.
- Shares that port between two pixel requesters, A and B, such as the test-pattern source and the particle renderer.
- Also sequences a built-in full-screen clear sweep.
- Sits between the pixel producers and the framebuffer memory, and drives its write_en/write_x/write_y/pixel_color inputs directly.

Parameters:
- DEFAULT_CLEAR, 12'h000, clear colour loaded into the clear-colour register at reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clear_start  in  1  single-cycle request to clear the whole framebuffer
- clear_color  in  12  clear colour [RRRR,GGGG,BBBB], sampled when clear_start is accepted
- clear_busy  out  1  high while the clear sweep is in progress
- a_valid  in  1  requester A has a pixel
- a_x  in  6  requester A column
- a_y  in  6  requester A row
- a_color  in  12  requester A colour
- a_ready  out  1  requester A pixel accepted this cycle
- b_valid  in  1  requester B has a pixel
- b_x  in  6  requester B column
- b_y  in  6  requester B row
- b_color  in  12  requester B colour
- b_ready  out  1  requester B pixel accepted this cycle
- write_en  out  1  framebuffer write strobe
- write_x  out  6  framebuffer column
- write_y  out  6  framebuffer row
- pixel_color  out  12  framebuffer write data

Behaviour:
- Clock and reset: single clock. Reset is asynchronous, active-high.
- Reset values:
  - write_en=0, write_x=0, write_y=0, pixel_color=0.
  - clear_busy=0, state=ARB, clear counter=0.
  - Last-grant pointer = B, so A wins the first tie.
  - Clear-colour register = DEFAULT_CLEAR.
- States: ARB and CLEAR.
- ARB, arbitration:
  - a_ready and b_ready are combinational from the valids, state, pointer and clear_start.
  - At most one ready is high in any cycle.
- ARB, grant rules:
  - Only one valid high: that requester is granted.
  - Both valid: grant the requester that was NOT granted last.
  - clear_start=1 in ARB: both readys are 0 that cycle and no grant occurs.
- ARB, transfer:
  - A transfer occurs when valid and ready are both high.
  - On the next edge the output registers take the granted x/y/color, write_en becomes 1, and the pointer updates to the granted requester.
  - Latency is 1 cycle from transfer to write_en. One transfer per cycle, back-to-back allowed.
  - No transfer: write_en=0 next cycle. Address and colour outputs hold their previous values.
- Requester rules:
  - A requester holds valid, x, y and color stable until ready is high.
  - A requester may not drop valid before it is accepted.
  - The arbiter does not check these rules.
- Fairness: with both requesters continuously valid, grants strictly alternate. Worst-case wait is 1 cycle outside CLEAR.
- ARB to CLEAR:
  - clear_start sampled high in ARB at cycle N latches clear_color into the clear-colour register.
  - State goes to CLEAR and the 12-bit counter goes to 0, both at N+1.
- CLEAR sweep:
  - Each cycle, the output registers take x=cnt[5:0], y=cnt[11:6] and the clear-colour register, with write_en=1. cnt then increments.
  - Write (0,0) appears at cycle N+2; write (63,63) appears at N+4097. That is exactly 4096 consecutive pulses.
- CLEAR exit: the cycle with cnt=4095 returns the state to ARB, with cnt wrapping to 0. Arbitration resumes at N+4097.
- CLEAR, other signals:
  - clear_busy is high for cycles N+1..N+4096.
  - a_ready=b_ready=0 throughout.
  - clear_start during CLEAR is ignored: no restart, and the clear-colour register does not change.
- Reset mid-operation:
  - Outputs go immediately to their reset values, the sweep is aborted and no pending grant is kept.
  - After release the block is in ARB. No clear resumes.
- Widths:
  - All coordinate and counter arithmetic is unsigned modulo its width.
  - Coordinates pass through unchanged, with no range check; the full 6-bit range is legal.

Test Plan:
- Idle after reset, a_valid=1 with (5,7,12'hF00) for one cycle -> a_ready=1 that cycle; next cycle write_en=1, write_x=5, write_y=7, pixel_color=12'hF00; write_en=0 the cycle after.
- a_valid and b_valid held high for 6 cycles with distinct pixels -> ready sequence A,B,A,B,A,B; six consecutive write_en pulses carry the matching pixels in that order.
- Pulse clear_start with clear_color=12'h00F -> clear_busy high for 4096 cycles; 4096 consecutive write_en pulses from (0,0) to (63,63) in raster order (x fastest), all 12'h00F; a_ready/b_ready stay 0.
- A valid (10,20,12'h0F0) asserted during CLEAR -> a_ready stays 0 until the sweep ends; A is accepted in the first ARB cycle; write follows 1 cycle later with its data unchanged.
- Reset asserted on the 1000th clear write -> write_en=0 and clear_busy=0 without waiting for a clock edge; after release, no clear writes and the arbiter grants A first on a tie.
- clear_start re-pulsed with 12'hFFF at clear pixel 2000 -> ignored; total 4096 writes, all in the original colour, with no extension.
